// File: rtl/delay_pkg.sv
// Shared constants and the packed tuple word for the delay_3 pipeline.
package delay_pkg;
  localparam int DELAY_W1    = 4;
  localparam int DELAY_W2    = 4;
  localparam int DELAY_DEPTH = 3;

  typedef logic [DELAY_W1+DELAY_W2-1:0] delay_word_t;
endpackage

// File: rtl/delay_3_if.sv
// Tuple bus: two input fields in, packed delayed word out.
interface delay_3_if
  import delay_pkg::*;
#(
  parameter int W1 = DELAY_W1,
  parameter int W2 = DELAY_W2
);
  logic [W1-1:0]    input1_i;
  logic [W2-1:0]    input2_i;
  logic [W1+W2-1:0] output__;

  modport master (output input1_i, output input2_i, input  output__);
  modport slave  (input  input1_i, input  input2_i, output output__);
endinterface

// File: rtl/delay_stage.sv
// One W-bit pipeline register with asynchronous active-high clear.
module delay_stage #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) q <= '0;
    else       q <= d;
  end
endmodule

// File: rtl/delay_3.sv
// Fixed-latency tuple pipeline: {input1, input2} appears on output__ DEPTH edges later.
module delay_3
  import delay_pkg::*;
#(
  parameter int W1    = DELAY_W1,
  parameter int W2    = DELAY_W2,
  parameter int DEPTH = DELAY_DEPTH
) (
  input logic       clk_i,
  input logic       rst_i,
  delay_3_if.slave  bus
);
  localparam int W = W1 + W2;

  // tap[0] is the packed input word; tap[k] is the output of register k-1.
  logic [DEPTH:0][W-1:0] tap;

  assign tap[0] = {bus.input1_i, bus.input2_i};

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    delay_stage #(.W(W)) u_stage (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d     (tap[k]),
      .q     (tap[k+1])
    );
  end

  assign bus.output__ = tap[DEPTH];
endmodule

// File: tb/tb_delay_3.sv
// Directed bench for delay_3: default 4+4/DEPTH=3 instance plus an 8+8/DEPTH=1 instance.
module tb_delay_3;
  import delay_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  delay_3_if #(.W1(4), .W2(4)) bus_a ();
  delay_3_if #(.W1(8), .W2(8)) bus_b ();

  delay_3 #(.W1(4), .W2(4), .DEPTH(3)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_a)
  );

  delay_3 #(.W1(8), .W2(8), .DEPTH(1)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_b)
  );

  typedef struct {
    logic [3:0]  in1;
    logic [3:0]  in2;
    delay_word_t exp;
  } vec_a_t;

  typedef struct {
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic [15:0] exp;
  } vec_b_t;

  vec_a_t va [14];
  vec_b_t vb [3];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h", name, got, exp);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset_midcycle();
    #1 rst = 1'b1;
    #1 check("async_clear_before_edge", {8'h00, bus_a.output__}, 16'h0000);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Each row: inputs applied on a negedge, output checked just after the following posedge.
    va[0]  = '{4'h0, 4'h1, 8'h00};
    va[1]  = '{4'h0, 4'h0, 8'h00};
    va[2]  = '{4'h0, 4'h0, 8'h01};
    va[3]  = '{4'h0, 4'h0, 8'h00};
    va[4]  = '{4'hA, 4'h5, 8'h00};
    va[5]  = '{4'h0, 4'h0, 8'h00};
    va[6]  = '{4'h0, 4'h0, 8'hA5};
    va[7]  = '{4'h1, 4'h2, 8'h00};
    va[8]  = '{4'h3, 4'h4, 8'h00};
    va[9]  = '{4'h5, 4'h6, 8'h12};
    va[10] = '{4'h7, 4'h8, 8'h34};
    va[11] = '{4'h0, 4'h0, 8'h56};
    va[12] = '{4'h0, 4'h0, 8'h78};
    va[13] = '{4'h0, 4'h0, 8'h00};

    vb[0] = '{8'hAB, 8'hCD, 16'hABCD};
    vb[1] = '{8'h01, 8'h80, 16'h0180};
    vb[2] = '{8'hFF, 8'h00, 16'hFF00};

    rst = 1'b1;
    bus_a.input1_i = 4'hF;
    bus_a.input2_i = 4'hF;
    bus_b.input1_i = 8'hFF;
    bus_b.input2_i = 8'hFF;

    // Reset held for two edges with all-ones inputs.
    for (int i = 0; i < 2; i++) begin
      after_edge();
      check($sformatf("reset_hold_a%0d", i), {8'h00, bus_a.output__}, 16'h0000);
      check($sformatf("reset_hold_b%0d", i), bus_b.output__, 16'h0000);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_a.input1_i = 4'h0;
    bus_a.input2_i = 4'h0;
    bus_b.input1_i = 8'h00;
    bus_b.input2_i = 8'h00;
    for (int i = 0; i < 3; i++) begin
      after_edge();
      check($sformatf("post_reset_%0d", i), {8'h00, bus_a.output__}, 16'h0000);
    end

    // Pulse, field order and streaming through the DEPTH=3 instance.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bus_a.input1_i = va[i].in1;
      bus_a.input2_i = va[i].in2;
      after_edge();
      check($sformatf("vec_a%0d", i), {8'h00, bus_a.output__}, {8'h00, va[i].exp});
    end

    // Pipeline full of 0xFF, then an asynchronous clear between edges.
    @(negedge clk);
    bus_a.input1_i = 4'hF;
    bus_a.input2_i = 4'hF;
    for (int i = 0; i < 3; i++) after_edge();
    check("ff_loaded", {8'h00, bus_a.output__}, 16'h00FF);
    @(negedge clk);
    bus_a.input1_i = 4'h0;
    bus_a.input2_i = 4'h0;
    pulse_reset_midcycle();
    check("after_release", {8'h00, bus_a.output__}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      after_edge();
      check($sformatf("ff_flushed_%0d", i), {8'h00, bus_a.output__}, 16'h0000);
    end

    // In-flight tuple discarded; first tuple after release arrives DEPTH edges later.
    @(negedge clk);
    bus_a.input1_i = 4'hC;
    bus_a.input2_i = 4'h3;
    after_edge();
    @(negedge clk);
    bus_a.input1_i = 4'h0;
    bus_a.input2_i = 4'h0;
    pulse_reset_midcycle();
    bus_a.input1_i = 4'h9;
    bus_a.input2_i = 4'h6;
    after_edge();
    check("midflight_e1", {8'h00, bus_a.output__}, 16'h0000);
    @(negedge clk);
    bus_a.input1_i = 4'h0;
    bus_a.input2_i = 4'h0;
    after_edge();
    check("midflight_e2", {8'h00, bus_a.output__}, 16'h0000);
    after_edge();
    check("midflight_e3", {8'h00, bus_a.output__}, 16'h0096);
    after_edge();
    check("midflight_e4", {8'h00, bus_a.output__}, 16'h0000);

    // DEPTH=1, 8+8 bit packing.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_b.input1_i = vb[i].in1;
      bus_b.input2_i = vb[i].in2;
      check($sformatf("vec_b%0d_before_edge", i), bus_b.output__,
            (i == 0) ? 16'h0000 : vb[i-1].exp);
      after_edge();
      check($sformatf("vec_b%0d", i), bus_b.output__, vb[i].exp);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
